// File: rtl/fifo_rr_push_arb.sv
// Round-robin push arbiter that lets N requesters share one downstream fifo.
// Each pushed entry carries its source tag. A per-requester outstanding
// counter, decremented from the consumer's tagged pops, caps how many fifo
// entries any one requester may occupy. A sticky error flags pops that do not
// match any outstanding entry.
module fifo_rr_push_arb #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int LG_D    = 3,
    parameter int MAX_OUT = 4,
    localparam int TAG_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               req_valid,
    input  logic [N*W-1:0]             req_data,
    output logic [N-1:0]               req_ready,
    output logic                       fifo_push,
    output logic [TAG_W+W-1:0]         fifo_in,
    input  logic                       fifo_full,
    input  logic                       fifo_pop,
    input  logic [TAG_W-1:0]           fifo_out_tag,
    output logic [N*(LG_D+1)-1:0]      outstanding,
    output logic                       err
);

    localparam int CW = LG_D + 1;

    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q [N];
    logic [CW-1:0]    cnt_d [N];
    logic             err_q, err_d;

    logic [N-1:0]     elig;
    logic [N-1:0]     grant;
    logic [N-1:0]     dec;
    logic             found;
    logic [TAG_W-1:0] idx;
    int               sel;
    int               cand;
    logic             tag_hit;

    // A requester may push only while under its outstanding cap and the fifo has room.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = req_valid[i] & (cnt_q[i] < CW'(MAX_OUT)) & ~fifo_full;
        end
    end

    // Rotating priority search starting at ptr_q, wrapping explicitly for any N.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        sel   = 0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && elig[cand]) begin
                found       = 1'b1;
                sel         = cand;
                idx         = TAG_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    // Push outputs; payload is zeroed when nothing is pushed.
    always_comb begin
        req_ready = grant;
        fifo_push = found;
        fifo_in   = '0;
        if (found) begin
            fifo_in = {idx, req_data[sel*W +: W]};
        end
    end

    // Next pointer: one past the winner, wrapping at N-1.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (idx == TAG_W'(N - 1)) ? '0 : idx + TAG_W'(1);
        end
    end

    // Counter update from grants and tagged pops; an unmatched pop sets the sticky error.
    always_comb begin
        tag_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            dec[i]   = fifo_pop & (fifo_out_tag == TAG_W'(i)) & (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (dec[i]) begin
                tag_hit = 1'b1;
            end
            if (grant[i] & ~dec[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec[i] & ~grant[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        err_d = err_q | (fifo_pop & ~tag_hit);
    end

    // Registered arbiter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Expose the counters and error flag directly from the flops.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            outstanding[i*CW +: CW] = cnt_q[i];
        end
        err = err_q;
    end

endmodule

// File: tb/tb_fifo_rr_push_arb.sv
module tb_fifo_rr_push_arb;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int LG_D    = 3;
    localparam int MAX_OUT = 4;
    localparam int TAG_W   = 2;
    localparam int CW      = LG_D + 1;
    localparam int DEPTH   = 1 << LG_D;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          req_valid;
    logic [N*W-1:0]        req_data;
    logic [N-1:0]          req_ready;
    logic                  fifo_push;
    logic [TAG_W+W-1:0]    fifo_in;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic [TAG_W-1:0]      fifo_out_tag;
    logic [N*CW-1:0]       outstanding;
    logic                  err;

    // second instance with a non-power-of-2 requester count
    logic [2:0]            req_valid3;
    logic [3*W-1:0]        req_data3;
    logic [2:0]            req_ready3;
    logic                  fifo_push3;
    logic [2+W-1:0]        fifo_in3;
    logic                  fifo_full3;
    logic                  fifo_pop3;
    logic [1:0]            fifo_out_tag3;
    logic [3*CW-1:0]       outstanding3;
    logic                  err3;

    always #5 clk = ~clk;

    fifo_rr_push_arb #(.N(N), .W(W), .LG_D(LG_D), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_push(fifo_push), .fifo_in(fifo_in),
        .fifo_full(fifo_full), .fifo_pop(fifo_pop), .fifo_out_tag(fifo_out_tag),
        .outstanding(outstanding), .err(err)
    );

    fifo_rr_push_arb #(.N(3), .W(W), .LG_D(LG_D), .MAX_OUT(MAX_OUT)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_data(req_data3),
        .req_ready(req_ready3), .fifo_push(fifo_push3), .fifo_in(fifo_in3),
        .fifo_full(fifo_full3), .fifo_pop(fifo_pop3), .fifo_out_tag(fifo_out_tag3),
        .outstanding(outstanding3), .err(err3)
    );

    int total = 0;
    int bad   = 0;

    // reference model: fifo contents as a queue of tags, plus per-requester counts
    int         m_cnt [N];
    int         m_ptr;
    bit         m_err;
    int         q [$];

    logic [N-1:0]       obs_rdy, exp_rdy;
    logic               obs_push;
    logic [TAG_W+W-1:0] obs_in, exp_in;
    logic [N*CW-1:0]    obs_out, exp_out;
    logic               obs_err;

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0;
        m_err = 1'b0;
        q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; req_data = '0; fifo_full = 1'b0; fifo_pop = 1'b0; fifo_out_tag = '0;
        req_valid3 = '0; req_data3 = '0; fifo_full3 = 1'b0; fifo_pop3 = 1'b0; fifo_out_tag3 = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive inputs, capture combinational outputs, advance the model, capture registered outputs.
    task automatic step(input logic [N-1:0] v, input logic pop, input logic use_tag,
                        input logic [TAG_W-1:0] tag);
        int idx;
        int t;
        @(negedge clk);
        req_valid = v;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
        fifo_full    = (q.size() == DEPTH);
        fifo_pop     = pop && (use_tag || q.size() > 0);
        fifo_out_tag = use_tag ? tag : ((q.size() > 0) ? TAG_W'(q[0]) : '0);
        idx = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (idx < 0 && v[j] && m_cnt[j] < MAX_OUT && !fifo_full) idx = j;
        end
        exp_rdy = '0;
        exp_in  = '0;
        if (idx >= 0) begin
            exp_rdy[idx] = 1'b1;
            exp_in = {TAG_W'(idx), req_data[idx*W +: W]};
        end
        #1;
        obs_rdy  = req_ready;
        obs_push = fifo_push;
        obs_in   = fifo_in;
        @(posedge clk);
        t = int'(fifo_out_tag);
        if (fifo_pop) begin
            if (t < N && m_cnt[t] != 0) m_cnt[t] = m_cnt[t] - 1;
            else m_err = 1'b1;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (idx >= 0) begin
            m_cnt[idx] = m_cnt[idx] + 1;
            m_ptr = (idx + 1) % N;
            q.push_back(idx);
        end
        #1;
        obs_out = outstanding;
        obs_err = err;
        for (int i = 0; i < N; i++) exp_out[i*CW +: CW] = CW'(m_cnt[i]);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b exp=0", fifo_push); end
        total++; if (fifo_in !== '0) begin bad++; $display("FAIL reset_fifo_in got=%h exp=0", fifo_in); end
        total++; if (outstanding !== '0) begin bad++; $display("FAIL reset_outstanding got=%h exp=0", outstanding); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_rr_fill();
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, 1'b0, 1'b0, '0);
            want = '0;
            want[c % N] = 1'b1;
            total++; if (obs_rdy !== want) begin bad++; $display("FAIL rr_order cyc=%0d got=%b exp=%b", c, obs_rdy, want); end
            total++; if (obs_in !== exp_in) begin bad++; $display("FAIL rr_fifo_in cyc=%0d got=%h exp=%h", c, obs_in, exp_in); end
        end
        step(4'b1111, 1'b0, 1'b0, '0);
        total++; if (obs_rdy !== 4'b0000 || obs_push !== 1'b0) begin bad++; $display("FAIL rr_full_block got=%b/%b exp=0000/0", obs_rdy, obs_push); end
        total++; if (obs_out !== 16'h2222) begin bad++; $display("FAIL rr_outstanding got=%h exp=2222", obs_out); end
    endtask

    task automatic test_single_limit();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(4'b0100, 1'b0, 1'b0, '0);
            total++; if (obs_rdy !== 4'b0100) begin bad++; $display("FAIL limit_grant cyc=%0d got=%b exp=0100", c, obs_rdy); end
        end
        step(4'b0100, 1'b0, 1'b0, '0);
        total++; if (obs_rdy !== 4'b0000) begin bad++; $display("FAIL limit_block got=%b exp=0000", obs_rdy); end
        total++; if (obs_out !== 16'h0400) begin bad++; $display("FAIL limit_count got=%h exp=0400", obs_out); end
        step(4'b0100, 1'b1, 1'b0, '0);
        total++; if (obs_rdy !== 4'b0000) begin bad++; $display("FAIL limit_pop_same_cycle got=%b exp=0000", obs_rdy); end
        step(4'b0100, 1'b0, 1'b0, '0);
        total++; if (obs_rdy !== 4'b0100) begin bad++; $display("FAIL limit_after_pop got=%b exp=0100", obs_rdy); end
    endtask

    task automatic test_inc_dec();
        do_reset();
        repeat (3) step(4'b0010, 1'b0, 1'b0, '0);
        step(4'b0010, 1'b1, 1'b0, '0);
        total++; if (obs_push !== 1'b1 || obs_in[TAG_W+W-1:W] !== 2'd1) begin bad++; $display("FAIL incdec_push got=%b tag=%0d exp=1 tag=1", obs_push, obs_in[TAG_W+W-1:W]); end
        total++; if (obs_out[1*CW +: CW] !== 4'd3) begin bad++; $display("FAIL incdec_count got=%0d exp=3", obs_out[1*CW +: CW]); end
    endtask

    task automatic test_full_pop();
        do_reset();
        repeat (8) step(4'b1111, 1'b0, 1'b0, '0);
        step(4'b0001, 1'b1, 1'b0, '0);
        total++; if (obs_rdy !== 4'b0000) begin bad++; $display("FAIL fullpop_same got=%b exp=0000", obs_rdy); end
        step(4'b0001, 1'b0, 1'b0, '0);
        total++; if (obs_rdy !== 4'b0001 || obs_push !== 1'b1) begin bad++; $display("FAIL fullpop_next got=%b/%b exp=0001/1", obs_rdy, obs_push); end
    endtask

    task automatic test_err();
        do_reset();
        step(4'b0000, 1'b1, 1'b1, 2'd3);
        total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", obs_err); end
        total++; if (obs_out !== 16'h0000) begin bad++; $display("FAIL err_counts got=%h exp=0000", obs_out); end
        step(4'b1111, 1'b0, 1'b0, '0);
        step(4'b1111, 1'b0, 1'b0, '0);
        total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", obs_err); end
        do_reset();
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_reset got=%b exp=0", err); end
        step(4'b1111, 1'b0, 1'b0, '0);
        total++; if (obs_rdy !== 4'b0001) begin bad++; $display("FAIL ptr_reset got=%b exp=0001", obs_rdy); end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic         p;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = N'($urandom_range(0, 15));
            p = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            step(v, p, 1'b0, '0);
            total++; if (obs_rdy !== exp_rdy || obs_push !== (|exp_rdy)) begin bad++; $display("FAIL rand_grant cyc=%0d got=%b/%b exp=%b", c, obs_rdy, obs_push, exp_rdy); end
            total++; if (obs_in !== exp_in) begin bad++; $display("FAIL rand_fifo_in cyc=%0d got=%h exp=%h", c, obs_in, exp_in); end
            total++; if (obs_out !== exp_out || obs_err !== m_err) begin bad++; $display("FAIL rand_state cyc=%0d got=%h/%b exp=%h/%b", c, obs_out, obs_err, exp_out, m_err); end
        end
    endtask

    task automatic test_n3();
        logic [2:0] want;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid3 = 3'b111;
            for (int i = 0; i < 3; i++) req_data3[i*W +: W] = $urandom;
            #1;
            want = '0;
            want[c % 3] = 1'b1;
            total++; if (req_ready3 !== want) begin bad++; $display("FAIL n3_order cyc=%0d got=%b exp=%b", c, req_ready3, want); end
            total++; if (fifo_in3 !== {2'(c % 3), req_data3[(c % 3)*W +: W]}) begin bad++; $display("FAIL n3_fifo_in cyc=%0d got=%h", c, fifo_in3); end
        end
        @(negedge clk);
        req_valid3 = '0;
    endtask

    initial begin
        test_reset();
        test_rr_fill();
        test_single_limit();
        test_inc_dec();
        test_full_pop();
        test_err();
        test_random();
        test_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
